// File: rtl/sparse_pkg.sv
// Shared types and lane geometry for the sparse datapath fetch path.
package sparse_pkg;

    localparam int unsigned CHANNEL_NUM = 4;
    localparam int unsigned N_LANES     = 3 * CHANNEL_NUM;
    localparam int unsigned LANE_IDW    = $clog2(N_LANES);

    // Position of a lane inside its PE channel (lane = 3*channel + field).
    typedef enum logic [1:0] {
        FIELD_VAL = 2'd0,
        FIELD_COL = 2'd1,
        FIELD_PTR = 2'd2
    } field_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/stream_fetcher_if.sv
// Config, ROM and lane-side signals of the stream fetcher.
interface stream_fetcher_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 10,
    parameter int unsigned LW = 10
);
    import sparse_pkg::*;

    logic                    cfg_we;
    logic [LANE_IDW-1:0]     cfg_lane;
    logic [AW-1:0]           cfg_base;
    logic [LW-1:0]           cfg_len;
    logic                    start;
    logic                    rom_en;
    logic [AW-1:0]           rom_addr;
    logic [DW-1:0]           rom_data;
    logic [N_LANES-1:0]      read;
    logic [N_LANES*DW-1:0]   out;
    logic [N_LANES-1:0]      empty;
    logic [N_LANES-1:0]      done;
    logic                    busy;

    modport master (
        output cfg_we, cfg_lane, cfg_base, cfg_len, start, rom_data, read,
        input  rom_en, rom_addr, out, empty, done, busy
    );

    modport slave (
        input  cfg_we, cfg_lane, cfg_base, cfg_len, start, rom_data, read,
        output rom_en, rom_addr, out, empty, done, busy
    );

endinterface

// File: rtl/lane_fifo.sv
// Single-lane synchronous FIFO; head word shown while non-empty, zero otherwise.
module lane_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW:0]   wr_q;
    logic [PW:0]   rd_q;

    assign empty = (wr_q == rd_q);
    assign dout  = empty ? '0 : mem[rd_q[PW-1:0]];

    // Storage array, written on push only.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q[PW-1:0]] <= din;
        end
    end

    // Read/write pointers with wrap bit; clr flushes the contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clr) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + (PW+1)'(1);
            end
            if (pop && !empty) begin
                rd_q <= rd_q + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/stream_fetcher.sv
// Streams per-lane ROM regions into lane FIFOs with round-robin, credit-gated fetch.
module stream_fetcher
    import sparse_pkg::*;
#(
    parameter int unsigned DW         = 8,
    parameter int unsigned AW         = 10,
    parameter int unsigned LW         = 10,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ROM_LAT    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_fetcher_if.slave bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IW = LANE_IDW + 1;

    state_e              state_q, state_d;
    logic [AW-1:0]       base_q   [N_LANES];
    logic [LW-1:0]       len_q    [N_LANES];
    logic [LW-1:0]       offset_q [N_LANES];
    logic [CW-1:0]       credit_q [N_LANES];
    logic [LANE_IDW-1:0] rr_q;
    logic                tag_v_q  [ROM_LAT];
    logic [LANE_IDW-1:0] tag_id_q [ROM_LAT];

    logic [N_LANES-1:0]    elig, grant_vec, push, pop, inflight, empty_c, done_c;
    logic                  grant_v;
    logic [LANE_IDW-1:0]   grant_id;
    logic [IW-1:0]         scan_idx;
    logic                  start_fire;
    logic [N_LANES*DW-1:0] out_c;

    assign start_fire = (state_q == ST_IDLE) && bus.start;

    // Lane may fetch when running, it has FIFO credit and words remain.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            elig[i] = (state_q == ST_RUN) && (credit_q[i] != '0) && (offset_q[i] < len_q[i]);
        end
    end

    // Round-robin arbiter: first eligible lane starting at rr_q; ineligible lanes are skipped.
    always_comb begin
        grant_v  = 1'b0;
        grant_id = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            scan_idx = {1'b0, rr_q} + IW'(k);
            if (32'(scan_idx) >= N_LANES) begin
                scan_idx = scan_idx - IW'(N_LANES);
            end
            if (!grant_v && elig[scan_idx[LANE_IDW-1:0]]) begin
                grant_v  = 1'b1;
                grant_id = scan_idx[LANE_IDW-1:0];
            end
        end
    end

    // Per-lane grant, write-back, pop, in-flight and done decode.
    always_comb begin
        grant_vec = '0;
        push      = '0;
        pop       = '0;
        inflight  = '0;
        done_c    = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            grant_vec[i] = grant_v && (grant_id == LANE_IDW'(i));
            push[i]      = tag_v_q[ROM_LAT-1] && (tag_id_q[ROM_LAT-1] == LANE_IDW'(i));
            pop[i]       = bus.read[i] && !empty_c[i];
            for (int unsigned j = 0; j < ROM_LAT; j++) begin
                if (tag_v_q[j] && (tag_id_q[j] == LANE_IDW'(i))) begin
                    inflight[i] = 1'b1;
                end
            end
            done_c[i] = (offset_q[i] == len_q[i]) && !inflight[i] && empty_c[i];
        end
    end

    // Next-state: IDLE->RUN on start, RUN->IDLE once every lane is done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (&done_c)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and round-robin pointer (next lane to consider).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (grant_v) begin
                rr_q <= (32'(grant_id) >= N_LANES - 1) ? '0 : grant_id + LANE_IDW'(1);
            end
        end
    end

    // Region table, writable only while idle; out-of-range lanes dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else if ((state_q == ST_IDLE) && bus.cfg_we && (32'(bus.cfg_lane) < N_LANES)) begin
            base_q[bus.cfg_lane] <= bus.cfg_base;
            len_q[bus.cfg_lane]  <= bus.cfg_len;
        end
    end

    // Fetch offsets and credits (FIFO occupancy plus in-flight reads).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                offset_q[i] <= '0;
                credit_q[i] <= CW'(FIFO_DEPTH);
            end
        end else if (start_fire) begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                offset_q[i] <= '0;
                credit_q[i] <= CW'(FIFO_DEPTH);
            end
        end else begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                if (grant_vec[i]) begin
                    offset_q[i] <= offset_q[i] + LW'(1);
                end
                credit_q[i] <= credit_q[i] + CW'(pop[i]) - CW'(grant_vec[i]);
            end
        end
    end

    // Lane-id tag pipeline matching the ROM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < ROM_LAT; j++) begin
                tag_v_q[j]  <= 1'b0;
                tag_id_q[j] <= '0;
            end
        end else begin
            tag_v_q[0]  <= grant_v;
            tag_id_q[0] <= grant_id;
            for (int unsigned j = 1; j < ROM_LAT; j++) begin
                tag_v_q[j]  <= tag_v_q[j-1];
                tag_id_q[j] <= tag_id_q[j-1];
            end
        end
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        lane_fifo #(
            .DW    (DW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (start_fire),
            .push  (push[g]),
            .din   (bus.rom_data),
            .pop   (pop[g]),
            .dout  (out_c[g*DW +: DW]),
            .empty (empty_c[g])
        );
    end

    assign bus.rom_en   = grant_v;
    assign bus.rom_addr = grant_v ? base_q[grant_id] + AW'(offset_q[grant_id]) : '0;
    assign bus.out      = out_c;
    assign bus.empty    = empty_c;
    assign bus.done     = done_c;
    assign bus.busy     = (state_q == ST_RUN);

endmodule

// File: tb/tb_stream_fetcher.sv
// Scoreboard bench for stream_fetcher: expected lane words queued at start, checked on pop.
module tb_stream_fetcher;
    import sparse_pkg::*;

    localparam int unsigned DW         = 8;
    localparam int unsigned AW         = 10;
    localparam int unsigned LW         = 10;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned ROM_LAT    = 1;
    localparam int unsigned ALL        = (1 << N_LANES) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_fetcher_if #(.DW(DW), .AW(AW), .LW(LW)) bus ();

    stream_fetcher #(
        .DW(DW), .AW(AW), .LW(LW), .FIFO_DEPTH(FIFO_DEPTH), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int tb_base [N_LANES];
    int tb_len  [N_LANES];
    logic [DW-1:0] exp_q [N_LANES][$];
    int addr_log [$];

    function automatic logic [DW-1:0] rom_word(int unsigned a);
        return DW'(a * 29 + (a >> 8) * 5 + 3);
    endfunction

    // Synchronous ROM, one cycle latency; junk when not enabled.
    always @(posedge clk) begin
        bus.rom_data <= bus.rom_en ? rom_word(32'(bus.rom_addr)) : DW'(8'hEE);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Log ROM addresses and check every popped word against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rom_en) addr_log.push_back(32'(bus.rom_addr));
            for (int i = 0; i < N_LANES; i++) begin
                if (bus.read[i] && !bus.empty[i]) begin
                    check_eq($sformatf("avail_l%0d", i), 32'(exp_q[i].size() != 0), 32'(1));
                    if (exp_q[i].size() != 0)
                        check_eq($sformatf("data_l%0d", i), 32'(bus.out[i*DW +: DW]),
                                 32'(exp_q[i].pop_front()));
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n        = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_lane = '0;
        bus.cfg_base = '0;
        bus.cfg_len  = '0;
        bus.start    = 1'b0;
        bus.read     = '0;
        for (int i = 0; i < N_LANES; i++) begin
            exp_q[i].delete();
            tb_base[i] = 0;
            tb_len[i]  = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic cfg(input int lane, input int base, input int len);
        bus.cfg_we   = 1'b1;
        bus.cfg_lane = LANE_IDW'(lane);
        bus.cfg_base = AW'(base);
        bus.cfg_len  = LW'(len);
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
        if (lane < N_LANES) begin
            tb_base[lane] = base;
            tb_len[lane]  = len;
        end
    endtask

    task automatic start_run();
        addr_log.delete();
        for (int i = 0; i < N_LANES; i++)
            for (int k = 0; k < tb_len[i]; k++)
                exp_q[i].push_back(rom_word((tb_base[i] + k) % (1 << AW)));
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        while (bus.busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_eq(tag, 32'(bus.busy), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string tag);
        for (int i = 0; i < N_LANES; i++)
            check_eq($sformatf("%s_left_l%0d", tag, i), 32'(exp_q[i].size()), 32'(0));
        check_eq({tag, "_done"}, 32'(bus.done), ALL);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gcnt;
        int n2;
        int c;

        // Reset state held for 10 cycles
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("rst_busy",   32'(bus.busy),   32'(0));
            check_eq("rst_rom_en", 32'(bus.rom_en), 32'(0));
            check_eq("rst_empty",  32'(bus.empty),  ALL);
            check_eq("rst_done",   32'(bus.done),   ALL);
            check_eq("rst_out",    32'(bus.out != '0), 32'(0));
        end
        @(posedge clk);
        #1;

        // Round-robin across 12 lanes of 4 words
        bus.read = '1;
        for (int i = 0; i < N_LANES; i++) cfg(i, 16 * i, 4);
        start_run();
        wait_idle("t2_idle", 300);
        check_eq("t2_ngrant", 32'(addr_log.size()), 32'(48));
        for (int k = 0; k < 48 && k < addr_log.size(); k++)
            check_eq($sformatf("t2_addr%0d", k), 32'(addr_log[k]), 32'(16 * (k % 12) + k / 12));
        check_drained("t2");

        // Back-pressure: lane 0 blocked, 40 words
        bus.read = '0;
        for (int i = 0; i < N_LANES; i++) cfg(i, 0, 0);
        cfg(0, 100, 40);
        start_run();
        repeat (40) @(negedge clk);
        check_eq("t3_hold_grants", 32'(addr_log.size()), 32'(16));
        check_eq("t3_busy", 32'(bus.busy), 32'(1));
        check_eq("t3_empty0", 32'(bus.empty[0]), 32'(0));
        @(posedge clk);
        #1;
        cfg(0, 500, 2);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t3_run_ignore", 32'(addr_log.size()), 32'(16));
        @(posedge clk);
        #1 bus.read = N_LANES'(1);
        wait_idle("t3_idle", 300);
        check_eq("t3_ngrant", 32'(addr_log.size()), 32'(40));
        check_drained("t3");

        // Skip-full: lane 2 blocked, others keep fetching every cycle
        bus.read = ~N_LANES'(4);
        for (int i = 0; i < N_LANES; i++) cfg(i, 64 * i, (i == 2) ? 40 : 8);
        start_run();
        gcnt = 0;
        for (int k = 0; k < 104; k++) begin
            @(negedge clk);
            if (bus.rom_en) gcnt++;
        end
        check_eq("t4_contig", 32'(gcnt), 32'(104));
        gcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.rom_en) gcnt++;
        end
        check_eq("t4_full_idle", 32'(gcnt), 32'(0));
        n2 = 0;
        foreach (addr_log[k]) if (addr_log[k] / 64 == 2) n2++;
        check_eq("t4_l2_grants", 32'(n2), 32'(16));
        @(posedge clk);
        #1 bus.read = '1;
        wait_idle("t4_idle", 300);
        check_eq("t4_ngrant", 32'(addr_log.size()), 32'(128));
        check_drained("t4");

        // Edges: zero-length lanes, address wrap, sustained pop+grant
        bus.read = '1;
        for (int i = 0; i < N_LANES; i++) cfg(i, 0, 0);
        cfg(0, 1020, 20);
        cfg(13, 5, 7);
        start_run();
        gcnt = 0;
        @(negedge clk);
        check_eq("t5_done_start", 32'(bus.done), ALL & ~32'(1));
        if (bus.rom_en) gcnt++;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            if (bus.rom_en) gcnt++;
        end
        check_eq("t5_contig", 32'(gcnt), 32'(20));
        wait_idle("t5_idle", 200);
        check_eq("t5_ngrant", 32'(addr_log.size()), 32'(20));
        for (int k = 0; k < 20 && k < addr_log.size(); k++)
            check_eq($sformatf("t5_addr%0d", k), 32'(addr_log[k]), 32'((1020 + k) % 1024));
        check_drained("t5");
        repeat (5) @(negedge clk);
        check_eq("t5_empty_idle", 32'(bus.empty), ALL);

        // Reset mid-run, then restart with new regions
        bus.read = '0;
        for (int i = 0; i < N_LANES; i++) cfg(i, 32 * i, 10);
        start_run();
        c = 0;
        while (addr_log.size() < 20 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check_eq("t6_reach20", 32'(addr_log.size() >= 20), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_busy",   32'(bus.busy),   32'(0));
        check_eq("t6_rom_en", 32'(bus.rom_en), 32'(0));
        check_eq("t6_empty",  32'(bus.empty),  ALL);
        check_eq("t6_done",   32'(bus.done),   ALL);
        check_eq("t6_out",    32'(bus.out != '0), 32'(0));
        for (int i = 0; i < N_LANES; i++) exp_q[i].delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.read = '1;
        for (int i = 0; i < N_LANES; i++) cfg(i, 600 + 16 * i, 5);
        start_run();
        wait_idle("t6_idle", 300);
        check_eq("t6_ngrant", 32'(addr_log.size()), 32'(60));
        check_drained("t6");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
